arc_debug_ctrl: RTL and testbench
=================================

// Module: arc_debug_ctrl
// PURPOSE
//  Run/step/breakpoint controller for the arc_cpu debug port; sits between host-side command logic and the CPU wrapper.
//  Gates the CPU step enable (RUN, STEP-N, HALT, PC breakpoint) and, once halted, walks the wrapper debug address space.
//  Each debug word is returned as a valid/ready snapshot stream, so a host can dump CPU state without manual address toggling.
// PARAMETERS
//  ADDR_W     7      debug address width (matches wrapper debug_addr)
//  DATA_W     32     debug data / PC / command-argument width
//  DUMP_FIRST 7'h00  first debug address dumped
//  DUMP_LAST  7'h43  last debug address dumped (inclusive, >= DUMP_FIRST)
//  AUTO_DUMP  1      1: breakpoint hit or STEP completion enters DUMP automatically
// PORTS
//  clk        in  1       system clock
//  aresetn    in  1       synchronous reset, active-low
//  cmd_valid  in  1       command valid
//  cmd_ready  out 1       command accepted when cmd_valid&&cmd_ready
//  cmd_op     in  3       0 HALT,1 RUN,2 STEP,3 SET_BP,4 CLR_BP,5 DUMP,6/7 illegal
//  cmd_arg    in  DATA_W  STEP: count N; SET_BP: breakpoint PC
//  cmd_err    out 1       1-cycle pulse: illegal op, or op not allowed in current state
//  pc_in      in  DATA_W  PC of next instruction the CPU will execute
//  cpu_step   out 1       CPU advances one instruction on each clk edge with cpu_step=1
//  halted     out 1       state==HALTED
//  bp_hit     out 1       1-cycle pulse when a breakpoint stops execution
//  dbg_addr   out ADDR_W  drives wrapper debug_addr
//  dbg_data   in  DATA_W  wrapper debug_data (combinational from dbg_addr)
//  dump_valid out 1       snapshot beat valid
//  dump_ready in  1       snapshot consumer ready
//  dump_addr  out ADDR_W  address of current beat
//  dump_data  out DATA_W  data of current beat
//  dump_last  out 1       beat is DUMP_LAST
// BEHAVIOUR
//  Reset (aresetn=0 at clk edge, any state): state HALTED; halted=1, cmd_ready=1; cpu_step, cmd_err, bp_hit, dump_valid,
//    dump_last=0; dbg_addr=0; steps_left=0; bp_en=0; bp_addr=0; bp_skip=0.
//  States: HALTED, RUN, STEP, DUMP_SET (address settle), DUMP_OUT (beat presented).
//  cmd_ready=1 in HALTED/RUN/STEP, 0 in DUMP_*.
//  HALTED accepts all legal ops.
//  RUN/STEP accept HALT, SET_BP, CLR_BP; RUN/STEP/DUMP there -> dropped, cmd_err pulse.
//  Illegal op -> cmd_err, no state change.
//  RUN: -> RUN, bp_skip=1.
//  STEP: steps_left=(N==0)?1:N, -> STEP, bp_skip=1.
//  HALT: -> HALTED next cycle, no dump.
//  SET_BP: bp_addr=arg, bp_en=1.  CLR_BP: bp_en=0.  DUMP (HALTED only): dbg_addr=DUMP_FIRST, -> DUMP_SET.
//  Breakpoint match bpm = bp_en && pc_in==bp_addr && !bp_skip.
//  cpu_step = (RUN || (STEP && steps_left!=0)) && !bpm, combinational.
//  bp_skip clears on the first cpu_step=1 cycle, so resuming at the breakpoint PC executes it once.
//  bpm in RUN/STEP: bp_hit pulse; -> DUMP_SET (AUTO_DUMP) else HALTED.
//  Accepted HALT in the same cycle as bpm: bp_hit still pulses, HALT wins (no dump).
//  STEP: steps_left decrements on each cpu_step; after the last step -> DUMP_SET (AUTO_DUMP) else HALTED.
//  steps_left is 32-bit, no wrap.
//  DUMP_SET: one settle cycle -> DUMP_OUT. DUMP_OUT: dump_valid=1, dump_addr=dbg_addr, dump_data=dbg_data,
//    dump_last=(dbg_addr==DUMP_LAST). dbg_addr is held stable while valid and not ready.
//  On dump_valid&&dump_ready: last beat -> HALTED, else dbg_addr+1 -> DUMP_SET. Min 2 cycles/beat.
//  cpu_step=0 throughout DUMP; CPU state is frozen during a dump.
//  Outside DUMP, dbg_addr keeps its last value.
// STRUCTURE
//  define.vh: `DBG_OP_* opcodes, state encodings.
//  Sub-module arc_debug_dump_seq: DUMP_SET/DUMP_OUT address walker and stream (start in, done out).
//  Parent holds run/step/bp FSM.
// TESTING
//  Reset, then idle 5 cycles -> halted=1, cpu_step=0, dump_valid=0, dbg_addr=0.
//  STEP arg=3 -> cpu_step high exactly 3 cycles; AUTO_DUMP=0 -> halted=1 next.
//  STEP arg=0 -> exactly 1 step.
//  SET_BP 0x1C, RUN, pc_in increments by 4 from 0 -> cpu_step low in the pc_in=0x1C cycle; bp_hit 1 cycle.
//    Then DUMP_FIRST..DUMP_LAST beats; re-RUN executes 0x1C once.
//  DUMP with dump_ready toggling 1/0 -> all beats in order, dbg_addr stable while stalled;
//    dump_last only on 7'h43; cmd_ready=0 throughout.
//  RUN, then HALT same cycle as bpm -> bp_hit=1, HALTED, no dump.
//    RUN while RUN -> cmd_err; op 6 -> cmd_err.
//  aresetn=0 mid-DUMP and mid-STEP(N=100) -> next cycle all reset values, bp_en=0.

Source files
------------

// File: rtl/arc_debug_ctrl_pkg.sv
// Shared opcodes, state types and helpers for the arc_cpu debug controller.
// Imported by arc_debug_ctrl and arc_debug_dump_seq.
package arc_debug_ctrl_pkg;

  localparam logic [2:0] DbgOpHalt  = 3'd0;
  localparam logic [2:0] DbgOpRun   = 3'd1;
  localparam logic [2:0] DbgOpStep  = 3'd2;
  localparam logic [2:0] DbgOpSetBp = 3'd3;
  localparam logic [2:0] DbgOpClrBp = 3'd4;
  localparam logic [2:0] DbgOpDump  = 3'd5;

  localparam int unsigned StepCntW = 32;

  typedef enum logic [1:0] {
    StHalted,
    StRun,
    StStep,
    StDump
  } ctrl_state_e;

  typedef enum logic [1:0] {
    SeqIdle,
    SeqSet,
    SeqOut
  } seq_state_e;

  // A step count of zero still executes one instruction.
  function automatic logic [StepCntW-1:0] step_count(input logic [StepCntW-1:0] n);
    return (n == '0) ? StepCntW'(1) : n;
  endfunction

endpackage

// File: rtl/arc_debug_dump_seq.sv
// Debug address walker: settles each address for one cycle, then presents it as
// a valid/ready beat until accepted; pulses done on the last accepted beat.
module arc_debug_dump_seq
  import arc_debug_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 7,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] DUMP_FIRST = 'h00,
  parameter logic [ADDR_W-1:0] DUMP_LAST  = 'h43
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              start,
  output logic              done,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q <= SeqIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      SeqIdle: begin
        if (start) begin
          state_d = SeqSet;
          addr_d  = DUMP_FIRST;
        end
      end
      SeqSet: state_d = SeqOut;
      SeqOut: begin
        // Address only moves on acceptance, so it stays stable under backpressure.
        if (dump_ready) begin
          if (addr_q == DUMP_LAST) begin
            state_d = SeqIdle;
          end else begin
            state_d = SeqSet;
            addr_d  = addr_q + 1'b1;
          end
        end
      end
      default: state_d = SeqIdle;
    endcase
  end

  assign dbg_addr   = addr_q;
  assign dump_valid = (state_q == SeqOut);
  assign dump_addr  = addr_q;
  assign dump_data  = dbg_data;
  assign dump_last  = dump_valid && (addr_q == DUMP_LAST);
  assign done       = dump_valid && dump_ready && dump_last;

endmodule

// File: rtl/arc_debug_ctrl.sv
// Run/step/breakpoint controller for the arc_cpu debug port; gates cpu_step and
// hands off to arc_debug_dump_seq to stream the wrapper debug space when halted.
module arc_debug_ctrl
  import arc_debug_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 7,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] DUMP_FIRST = 'h00,
  parameter logic [ADDR_W-1:0] DUMP_LAST  = 'h43,
  parameter bit                AUTO_DUMP  = 1'b1
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_arg,
  output logic              cmd_err,
  input  logic [DATA_W-1:0] pc_in,
  output logic              cpu_step,
  output logic              halted,
  output logic              bp_hit,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last
);

  ctrl_state_e         state_q, state_d;
  logic [StepCntW-1:0] steps_left_q, steps_left_d;
  logic                bp_en_q, bp_en_d;
  logic [DATA_W-1:0]   bp_addr_q, bp_addr_d;
  logic                bp_skip_q, bp_skip_d;

  logic cmd_fire;
  logic bpm;
  logic exec_stop;
  logic dump_start;
  logic dump_done;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q      <= StHalted;
      steps_left_q <= '0;
      bp_en_q      <= 1'b0;
      bp_addr_q    <= '0;
      bp_skip_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_left_q <= steps_left_d;
      bp_en_q      <= bp_en_d;
      bp_addr_q    <= bp_addr_d;
      bp_skip_q    <= bp_skip_d;
    end
  end

  assign cmd_ready = (state_q != StDump);
  assign halted    = (state_q == StHalted);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign bpm       = bp_en_q && (pc_in == bp_addr_q) && !bp_skip_q;
  assign cpu_step  = ((state_q == StRun) || ((state_q == StStep) && (steps_left_q != '0))) && !bpm;

  always_comb begin
    state_d      = state_q;
    steps_left_d = steps_left_q;
    bp_en_d      = bp_en_q;
    bp_addr_d    = bp_addr_q;
    bp_skip_d    = bp_skip_q;
    cmd_err      = 1'b0;
    bp_hit       = 1'b0;
    exec_stop    = 1'b0;
    dump_start   = 1'b0;

    if (cpu_step) begin
      bp_skip_d = 1'b0;
    end
    if (cpu_step && (state_q == StStep)) begin
      steps_left_d = steps_left_q - 1'b1;
    end

    unique case (state_q)
      StRun, StStep: begin
        if (bpm) begin
          bp_hit    = 1'b1;
          exec_stop = 1'b1;
        end else if ((state_q == StStep) && (steps_left_q == StepCntW'(1))) begin
          exec_stop = 1'b1;
        end
      end
      StDump: begin
        if (dump_done) begin
          state_d = StHalted;
        end
      end
      default: ;
    endcase

    if (exec_stop) begin
      if (AUTO_DUMP) begin
        dump_start = 1'b1;
        state_d    = StDump;
      end else begin
        state_d = StHalted;
      end
    end

    // Commands are resolved last so an accepted HALT overrides a breakpoint stop.
    if (cmd_fire) begin
      case (cmd_op)
        DbgOpHalt: begin
          state_d    = StHalted;
          dump_start = 1'b0;
        end
        DbgOpRun: begin
          if (halted) begin
            state_d   = StRun;
            bp_skip_d = 1'b1;
          end else begin
            cmd_err = 1'b1;
          end
        end
        DbgOpStep: begin
          if (halted) begin
            state_d      = StStep;
            steps_left_d = step_count(StepCntW'(cmd_arg));
            bp_skip_d    = 1'b1;
          end else begin
            cmd_err = 1'b1;
          end
        end
        DbgOpSetBp: begin
          bp_addr_d = cmd_arg;
          bp_en_d   = 1'b1;
        end
        DbgOpClrBp: bp_en_d = 1'b0;
        DbgOpDump: begin
          if (halted) begin
            state_d    = StDump;
            dump_start = 1'b1;
          end else begin
            cmd_err = 1'b1;
          end
        end
        default: cmd_err = 1'b1;
      endcase
    end
  end

  arc_debug_dump_seq #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DUMP_FIRST(DUMP_FIRST),
    .DUMP_LAST (DUMP_LAST)
  ) u_dump_seq (
    .clk       (clk),
    .aresetn   (aresetn),
    .start     (dump_start),
    .done      (dump_done),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_last (dump_last)
  );

endmodule

// File: tb/tb_arc_debug_ctrl.sv
// Self-checking bench for arc_debug_ctrl: emulated CPU (PC advances by 4 per step),
// random debug memory, and expectations computed from instruction/beat arithmetic.
module tb_arc_debug_ctrl;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;
  localparam logic [6:0]  FIRST  = 7'h00;
  localparam logic [6:0]  LAST   = 7'h43;
  localparam int          NBEATS = 68;

  localparam logic [2:0] OpHalt = 3'd0, OpRun = 3'd1, OpStep = 3'd2;
  localparam logic [2:0] OpSetBp = 3'd3, OpClrBp = 3'd4, OpDump = 3'd5;

  logic              clk;
  logic              aresetn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_arg;
  logic              cmd_err;
  logic [DATA_W-1:0] pc_in;
  logic              cpu_step;
  logic              halted;
  logic              bp_hit;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  logic [31:0] mem [128];
  logic [31:0] pc;

  assign pc_in    = pc;
  assign dbg_data = mem[dbg_addr];

  arc_debug_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DUMP_FIRST(FIRST),
    .DUMP_LAST (LAST),
    .AUTO_DUMP (1'b1)
  ) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cmd_err   (cmd_err),
    .pc_in     (pc_in),
    .cpu_step  (cpu_step),
    .halted    (halted),
    .bp_hit    (bp_hit),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_last (dump_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec, n_miss;
  int n_step, n_bp, n_err, rdy_mode;
  int stall_viol, rdy_viol, step_viol;
  bit in_dump, prev_stall;
  logic [6:0]  prev_addr;
  logic [31:0] step_pcs[$];
  logic [6:0]  b_addr[$];
  logic [31:0] b_data[$];
  bit          b_last[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    n_step = 0; n_bp = 0; n_err = 0;
    stall_viol = 0; rdy_viol = 0; step_viol = 0;
    in_dump = 1'b0; prev_stall = 1'b0; prev_addr = '0;
    step_pcs.delete(); b_addr.delete(); b_data.delete(); b_last.delete();
  endtask

  // One clock cycle: called just after a falling edge, returns at the next one.
  task automatic tick();
    bit stepped;
    case (rdy_mode)
      0:       dump_ready = 1'b1;
      1:       dump_ready = !dump_ready;
      default: dump_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    stepped = cpu_step;
    if (cpu_step) begin
      n_step++;
      step_pcs.push_back(pc);
    end
    if (bp_hit) n_bp++;
    if (cmd_err) n_err++;
    if (dump_valid) in_dump = 1'b1;
    if (in_dump && cmd_ready) rdy_viol++;
    if (in_dump && cpu_step) step_viol++;
    if (prev_stall && !(dump_valid && dump_addr == prev_addr && dbg_addr == prev_addr))
      stall_viol++;
    prev_stall = dump_valid && !dump_ready;
    prev_addr  = dump_addr;
    if (dump_valid && dump_ready) begin
      b_addr.push_back(dump_addr);
      b_data.push_back(dump_data);
      b_last.push_back(dump_last);
      if (dump_last) in_dump = 1'b0;
    end
    @(posedge clk);
    #1;
    if (stepped) pc = pc + 32'd4;
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_arg   = '0;
  endtask

  task automatic wait_halt(input string tag, input int limit);
    int i = 0;
    while (!halted && i < limit) begin
      tick();
      i++;
    end
    chk({tag, "_halt_timeout"}, 32'(halted), 32'd1);
  endtask

  function automatic int count_pc(input logic [31:0] v);
    int c = 0;
    foreach (step_pcs[i]) if (step_pcs[i] == v) c++;
    return c;
  endfunction

  task automatic check_dump(input string tag);
    int bad = 0;
    chk({tag, "_beats"}, 32'(b_addr.size()), 32'(NBEATS));
    foreach (b_addr[i]) begin
      if (32'(b_addr[i]) != 32'(FIRST) + 32'(i) || b_data[i] !== mem[b_addr[i]] ||
          b_last[i] != (i == b_addr.size() - 1))
        bad++;
    end
    chk({tag, "_beat_order"}, 32'(bad), 32'd0);
    chk({tag, "_stall_hold"}, 32'(stall_viol), 32'd0);
    chk({tag, "_ready_low"}, 32'(rdy_viol), 32'd0);
    chk({tag, "_no_step"}, 32'(step_viol), 32'd0);
    chk({tag, "_addr_kept"}, 32'(dbg_addr), 32'(LAST));
  endtask

  initial begin
    int n, k;
    logic [31:0] pc0, b;
    n_vec = 0; n_miss = 0; rdy_mode = 0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    pc = '0;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; dump_ready = 1'b1;
    clr_mon();
    @(negedge clk);

    repeat (3) tick();
    aresetn = 1'b1;
    clr_mon();
    repeat (5) tick();
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_cpu_step", 32'(cpu_step), 32'd0);
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_dbg_addr", 32'(dbg_addr), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_pulses", 32'(n_bp + n_err + n_step), 32'd0);

    clr_mon();
    send(OpStep, 32'd3);
    wait_halt("step3", 2000);
    chk("step3_count", 32'(n_step), 32'd3);
    chk("step3_pc", pc, 32'd12);
    check_dump("step3");

    clr_mon();
    send(OpStep, 32'd0);
    wait_halt("step0", 2000);
    chk("step0_count", 32'(n_step), 32'd1);
    chk("step0_beats", 32'(b_addr.size()), 32'(NBEATS));

    for (int r = 0; r < 3; r++) begin
      clr_mon();
      rdy_mode = 2;
      n   = $urandom_range(1, 20);
      pc0 = pc;
      send(OpStep, 32'(n));
      wait_halt("stepn", 2000);
      chk("stepn_count", 32'(n_step), 32'(n));
      chk("stepn_pc", pc, pc0 + 32'(4 * n));
      check_dump("stepn");
    end

    pc = '0;
    clr_mon();
    rdy_mode = 1;
    send(OpSetBp, 32'h1C);
    send(OpRun, 32'd0);
    wait_halt("bp", 2000);
    chk("bp_steps", 32'(n_step), 32'd7);
    chk("bp_hit_once", 32'(n_bp), 32'd1);
    chk("bp_pc", pc, 32'h1C);
    chk("bp_not_exec", 32'(count_pc(32'h1C)), 32'd0);
    check_dump("bp");

    clr_mon();
    rdy_mode = 0;
    send(OpRun, 32'd0);
    repeat (10) tick();
    send(OpHalt, 32'd0);
    tick();
    chk("rerun_halted", 32'(halted), 32'd1);
    chk("rerun_steps", 32'(n_step), 32'd11);
    chk("rerun_first_pc", (step_pcs.size() > 0) ? step_pcs[0] : 32'hFFFF_FFFF, 32'h1C);
    chk("rerun_bp_once", 32'(count_pc(32'h1C)), 32'd1);
    chk("rerun_no_hit", 32'(n_bp), 32'd0);

    clr_mon();
    rdy_mode = 2;
    k = $urandom_range(1, 8);
    send(OpSetBp, pc + 32'(4 * k));
    send(OpStep, 32'(k + 5));
    wait_halt("stepbp", 2000);
    chk("stepbp_steps", 32'(n_step), 32'(k));
    chk("stepbp_hit", 32'(n_bp), 32'd1);
    check_dump("stepbp");

    clr_mon();
    rdy_mode = 0;
    b = pc + 32'd20;
    send(OpSetBp, b);
    send(OpRun, 32'd0);
    for (int i = 0; i < 50 && pc != b; i++) tick();
    send(OpHalt, 32'd0);
    repeat (4) tick();
    chk("hbp_hit", 32'(n_bp), 32'd1);
    chk("hbp_halted", 32'(halted), 32'd1);
    chk("hbp_no_dump", 32'(b_addr.size()), 32'd0);
    chk("hbp_steps", 32'(n_step), 32'd5);
    chk("hbp_pc", pc, b);

    clr_mon();
    send(OpClrBp, 32'd0);
    send(3'd7, 32'd0);
    chk("err7_halted", 32'(halted), 32'd1);
    send(OpRun, 32'd0);
    tick();
    send(OpRun, 32'd0);
    send(3'd6, 32'd0);
    send(OpDump, 32'd0);
    send(OpStep, 32'd4);
    chk("err_still_run", 32'(halted), 32'd0);
    send(OpHalt, 32'd0);
    tick();
    chk("err_count", 32'(n_err), 32'd5);
    chk("err_halted", 32'(halted), 32'd1);
    chk("err_no_dump", 32'(b_addr.size()), 32'd0);

    clr_mon();
    send(OpDump, 32'd0);
    repeat (9) tick();
    chk("mid_dump_active", 32'(cmd_ready), 32'd0);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    chk("rstd_halted", 32'(halted), 32'd1);
    chk("rstd_ready", 32'(cmd_ready), 32'd1);
    chk("rstd_valid", 32'(dump_valid), 32'd0);
    chk("rstd_dbg_addr", 32'(dbg_addr), 32'd0);
    chk("rstd_cpu_step", 32'(cpu_step), 32'd0);

    clr_mon();
    b = pc + 32'd200;
    send(OpSetBp, b);
    send(OpStep, 32'd100);
    repeat (10) tick();
    chk("mid_step_running", 32'(halted), 32'd0);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    chk("rsts_halted", 32'(halted), 32'd1);
    chk("rsts_cpu_step", 32'(cpu_step), 32'd0);
    chk("rsts_valid", 32'(dump_valid), 32'd0);
    chk("rsts_dbg_addr", 32'(dbg_addr), 32'd0);
    clr_mon();
    send(OpRun, 32'd0);
    repeat (60) tick();
    send(OpHalt, 32'd0);
    tick();
    chk("rsts_bp_cleared", 32'(n_bp), 32'd0);
    chk("rsts_run_steps", 32'(n_step), 32'd61);
    chk("rsts_passed_bp", 32'(count_pc(b)), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
